// File: rtl/shutoff_countdown.sv
// rtl/shutoff_countdown.sv - fan shutoff timer: btn cycles 1/3/5-unit settings, counts down whole seconds, pulses timeout.
// Optional pre-shutoff warning (warn output, blinking led) is built when SHUTOFF_WARN_EN is defined.
module shutoff_countdown #(
  parameter int TICK_CYCLES  = 100_000_000,
  parameter int STEP_SECONDS = 3600,
  parameter int WARN_SECONDS = 60
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        btn,
  input  logic [7:0]  duty,
  output logic        timeout,
  output logic [2:0]  led,
  output logic [16:0] remain_sec,
  output logic        warn
);

  localparam int              PW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0]   PRE_MAX  = PW'(TICK_CYCLES - 1);
  localparam logic [16:0]     LOAD1    = 17'(STEP_SECONDS);
  localparam logic [16:0]     LOAD3    = 17'(3 * STEP_SECONDS);
  localparam logic [16:0]     LOAD5    = 17'(5 * STEP_SECONDS);
  localparam logic [16:0]     WARN_LIM = 17'(WARN_SECONDS);

  typedef enum logic [1:0] {IDLE, SET1, SET3, SET5} state_t;

  state_t        state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic [16:0]   remain_n;
  logic          timeout_n;
  logic [2:0]    led_n;
  logic          warn_n;
  logic          tick;
  logic          reload;
  logic          dec;

  function automatic logic [2:0] led_pat(input state_t s);
    case (s)
      SET1:    return 3'b001;
      SET3:    return 3'b011;
      SET5:    return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [16:0] load_val(input state_t s);
    case (s)
      SET1:    return LOAD1;
      SET3:    return LOAD3;
      SET5:    return LOAD5;
      default: return 17'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state      <= IDLE;
      pre        <= '0;
      remain_sec <= '0;
      timeout    <= 1'b0;
      led        <= 3'b000;
      warn       <= 1'b0;
    end else begin
      state      <= state_n;
      pre        <= pre_n;
      remain_sec <= remain_n;
      timeout    <= timeout_n;
      led        <= led_n;
      warn       <= warn_n;
    end
  end

  always_comb begin
    state_n   = state;
    pre_n     = pre;
    remain_n  = remain_sec;
    timeout_n = 1'b0;
    reload    = 1'b0;
    dec       = 1'b0;
    tick      = (state != IDLE) && (pre == PRE_MAX);

    // Fan off wins over everything; btn beats a coincident tick.
    if (duty == 8'd0) begin
      state_n  = IDLE;
      pre_n    = '0;
      remain_n = '0;
    end else if (btn) begin
      case (state)
        IDLE:    state_n = SET1;
        SET1:    state_n = SET3;
        SET3:    state_n = SET5;
        default: state_n = IDLE;
      endcase
      reload   = 1'b1;
      pre_n    = '0;
      remain_n = load_val(state_n);
    end else if (state != IDLE) begin
      if (tick) begin
        pre_n = '0;
        if (remain_sec <= 17'd1) begin
          state_n   = IDLE;
          remain_n  = '0;
          timeout_n = (remain_sec == 17'd1);
        end else begin
          remain_n = remain_sec - 17'd1;
          dec      = 1'b1;
        end
      end else begin
        pre_n = pre + PW'(1);
      end
    end

`ifdef SHUTOFF_WARN_EN
    warn_n = (state_n != IDLE) && (remain_n != 17'd0) && (remain_n <= WARN_LIM);
    led_n  = led_pat(state_n);
    // Inside the window each tick blinks; the first tick in the window goes dark.
    if (dec && warn_n)
      led_n = (warn && led == 3'b000) ? led_pat(state_n) : 3'b000;
    else if (state_n != IDLE && !reload && !dec)
      led_n = led;
`else
    warn_n = 1'b0;
    led_n  = led_pat(state_n);
`endif
  end

endmodule

// File: tb/tb_shutoff_countdown.sv
// tb/tb_shutoff_countdown.sv - self-checking bench for shutoff_countdown (vector table plus corner sequences).
module tb_shutoff_countdown;

  localparam int TICK = 10;
  localparam int STEP = 4;
  localparam int WARN = 2;
`ifdef SHUTOFF_WARN_EN
  localparam logic WE = 1'b1;
`else
  localparam logic WE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_p;
  logic        btn;
  logic [7:0]  duty;
  logic        timeout;
  logic [2:0]  led;
  logic [16:0] remain_sec;
  logic        warn;

  always #5 clk = ~clk;

  shutoff_countdown #(
    .TICK_CYCLES (TICK),
    .STEP_SECONDS(STEP),
    .WARN_SECONDS(WARN)
  ) dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .btn       (btn),
    .duty      (duty),
    .timeout   (timeout),
    .led       (led),
    .remain_sec(remain_sec),
    .warn      (warn)
  );

  typedef struct {
    logic        btn;
    logic [7:0]  duty;
    int          wait_cyc;
    logic [2:0]  led;
    logic [16:0] remain;
    logic        timeout;
    logic        warn;
  } vec_t;

  typedef struct {
    string       name;
    logic [21:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  errors = 0;
  int  checks = 0;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic sb_push(input string name, input logic [2:0] l, input logic [16:0] r,
                         input logic t, input logic w);
    sb_t e;
    e.name = name;
    e.exp  = {l, r, t, w};
    sbq.push_back(e);
  endtask

  task automatic sb_check();
    sb_t         e;
    logic [21:0] act;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e   = sbq.pop_front();
      act = {led, remain_sec, timeout, warn};
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got led=%b remain=%0d timeout=%b warn=%b, expected led=%b remain=%0d timeout=%b warn=%b",
                 e.name, act[21:19], act[18:2], act[1], act[0],
                 e.exp[21:19], e.exp[18:2], e.exp[1], e.exp[0]);
      end
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    btn     = 1'b0;
    duty    = 8'd100;
    cyc(1);
    reset_p = 1'b0;
  endtask

  task automatic pulse_btn();
    btn = 1'b1;
    cyc(1);
    btn = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    btn  = v.btn;
    duty = v.duty;
    sb_push(name, v.led, v.remain, v.timeout, v.warn);
    cyc(1);
    btn = 1'b0;
    if (v.wait_cyc > 1) cyc(v.wait_cyc - 1);
    sb_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[14];
    int   pulses;
    int   first;
    int   n;

    vt[0]  = '{1'b1, 8'd100, 3,  3'b001, 17'd4,  1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'd100, 3,  3'b011, 17'd12, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 8'd100, 3,  3'b111, 17'd20, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 8'd100, 3,  3'b000, 17'd0,  1'b0, 1'b0};
    vt[4]  = '{1'b0, 8'd100, 5,  3'b000, 17'd0,  1'b0, 1'b0};
    vt[5]  = '{1'b1, 8'd0,   2,  3'b000, 17'd0,  1'b0, 1'b0};
    vt[6]  = '{1'b1, 8'd100, 1,  3'b001, 17'd4,  1'b0, 1'b0};
    vt[7]  = '{1'b0, 8'd100, 10, 3'b001, 17'd3,  1'b0, 1'b0};
    vt[8]  = '{1'b0, 8'd100, 10, (WE ? 3'b000 : 3'b001), 17'd2, 1'b0, WE};
    vt[9]  = '{1'b0, 8'd100, 9,  (WE ? 3'b000 : 3'b001), 17'd2, 1'b0, WE};
    vt[10] = '{1'b0, 8'd100, 1,  3'b001, 17'd1,  1'b0, WE};
    vt[11] = '{1'b0, 8'd100, 9,  3'b001, 17'd1,  1'b0, WE};
    vt[12] = '{1'b0, 8'd100, 1,  3'b000, 17'd0,  1'b1, 1'b0};
    vt[13] = '{1'b0, 8'd100, 1,  3'b000, 17'd0,  1'b0, 1'b0};

    reset_p = 1'b1;
    btn     = 1'b0;
    duty    = 8'd100;
    @(negedge clk);
    sb_push("reset_state", 3'b000, 17'd0, 1'b0, 1'b0);
    sb_check();
    reset_p = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Full SET1 countdown: exactly one timeout pulse, 40 cycles after the press.
    do_reset();
    pulse_btn();
    sb_push("a_load", 3'b001, 17'd4, 1'b0, 1'b0);
    sb_check();
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= 45; i++) begin
      cyc(1);
      if (timeout === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    check_int("a_timeout_pulses", pulses, 1);
    check_int("a_timeout_cycle", first, 40);
    sb_push("a_end", 3'b000, 17'd0, 1'b0, 1'b0);
    sb_check();

    // Fan switched off mid-countdown, then btn while off.
    do_reset();
    pulse_btn();
    pulse_btn();
    sb_push("b_set3", 3'b011, 17'd12, 1'b0, 1'b0);
    sb_check();
    n      = 0;
    pulses = 0;
    while (remain_sec !== 17'd7 && n < 100) begin
      cyc(1);
      n++;
      if (timeout === 1'b1) pulses++;
    end
    check_int("b_cycles_to_7", n, 50);
    duty = 8'd0;
    cyc(1);
    sb_push("b_duty0", 3'b000, 17'd0, 1'b0, 1'b0);
    sb_check();
    btn = 1'b1;
    cyc(1);
    btn = 1'b0;
    sb_push("b_btn_duty0", 3'b000, 17'd0, 1'b0, 1'b0);
    sb_check();
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (timeout === 1'b1) pulses++;
    end
    check_int("b_no_timeout", pulses, 0);

    // btn coinciding with the terminal tick reloads instead of timing out.
    do_reset();
    duty = 8'd100;
    pulse_btn();
    cyc(39);
    sb_push("c_before", 3'b001, 17'd1, 1'b0, WE);
    sb_check();
    btn = 1'b1;
    cyc(1);
    btn = 1'b0;
    sb_push("c_reload", 3'b011, 17'd12, 1'b0, 1'b0);
    sb_check();
    cyc(1);
    sb_push("c_after", 3'b011, 17'd12, 1'b0, 1'b0);
    sb_check();

    // Asynchronous reset between clock edges in SET5.
    do_reset();
    pulse_btn();
    pulse_btn();
    pulse_btn();
    sb_push("d_set5", 3'b111, 17'd20, 1'b0, 1'b0);
    sb_check();
    cyc(3);
    #2;
    reset_p = 1'b1;
    #1;
    sb_push("d_async", 3'b000, 17'd0, 1'b0, 1'b0);
    sb_check();
    @(negedge clk);
    reset_p = 1'b0;
    cyc(2);
    sb_push("d_after", 3'b000, 17'd0, 1'b0, 1'b0);
    sb_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
